// File: rtl/qpll_reset_ctrl_pkg.sv
// Shared state encodings and counter sizing for the QPLL reset controller.
// STATE_OUT exposes these encodings directly, so the values are fixed.
package qpll_reset_pkg;

  typedef enum logic [2:0] {
    ST_PWRUP_WAIT  = 3'd0,
    ST_ASSERT_RST  = 3'd1,
    ST_WAIT_LOCK   = 3'd2,
    ST_LOCK_FILTER = 3'd3,
    ST_READY       = 3'd4,
    ST_WAIT_REFCLK = 3'd5,
    ST_FAIL        = 3'd6
  } qpll_state_e;

  localparam logic [2:0] S_PWRUP_WAIT  = 3'(ST_PWRUP_WAIT);
  localparam logic [2:0] S_ASSERT_RST  = 3'(ST_ASSERT_RST);
  localparam logic [2:0] S_WAIT_LOCK   = 3'(ST_WAIT_LOCK);
  localparam logic [2:0] S_LOCK_FILTER = 3'(ST_LOCK_FILTER);
  localparam logic [2:0] S_READY       = 3'(ST_READY);
  localparam logic [2:0] S_WAIT_REFCLK = 3'(ST_WAIT_REFCLK);
  localparam logic [2:0] S_FAIL        = 3'(ST_FAIL);

  // Width of the shared cycle counter: clog2 of the largest cycle count.
  function automatic int cnt_width(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/qpll_reset_ctrl_if.sv
// Reset/lock interface between the QPLL common block and its reset controller.
// master = controller side, slave = common-block side.
interface qpll_reset_ctrl_if;
  logic       QPLLLOCK_IN;
  logic       QPLLREFCLKLOST_IN;
  logic       QPLLRESET_OUT;
  logic       QPLL_READY_OUT;
  logic       FAIL_OUT;
  logic [3:0] RETRY_COUNT_OUT;
  logic [2:0] STATE_OUT;

  modport master (
    input  QPLLLOCK_IN, QPLLREFCLKLOST_IN,
    output QPLLRESET_OUT, QPLL_READY_OUT, FAIL_OUT, RETRY_COUNT_OUT, STATE_OUT
  );

  modport slave (
    output QPLLLOCK_IN, QPLLREFCLKLOST_IN,
    input  QPLLRESET_OUT, QPLL_READY_OUT, FAIL_OUT, RETRY_COUNT_OUT, STATE_OUT
  );
endinterface

// File: rtl/qpll_reset_ctrl_sync_2ff.sv
// Two-flop synchronizer for asynchronous status inputs; flops clear to 0 on reset.
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/qpll_reset_ctrl.sv
// QPLL common-block reset sequencer and lock monitor; its ready output gates
// the channel TX/RX reset FSMs.
//
// state        | meaning
// PWRUP_WAIT   | QPLLRESET held after controller reset while configuration settles
// ASSERT_RST   | retry QPLLRESET pulse
// WAIT_LOCK    | QPLLRESET released, waiting for lock with timeout
// LOCK_FILTER  | lock seen, requiring it to stay high
// READY        | lock stable, ready asserted
// WAIT_REFCLK  | reference clock lost, QPLLRESET held until it is back and stable
// FAIL         | retries exhausted, terminal until RESET_IN
module qpll_reset_ctrl
  import qpll_reset_pkg::*;
#(
  parameter int PWRUP_WAIT_CYCLES   = 300,
  parameter int RESET_PULSE_CYCLES  = 8,
  parameter int LOCK_TIMEOUT_CYCLES = 50000,
  parameter int LOCK_FILTER_CYCLES  = 16,
  parameter int MAX_RETRIES         = 7
) (
  input logic                SYSCLK_IN,
  input logic                RESET_IN,
  qpll_reset_ctrl_if.master  qpll
);

  localparam int CW = cnt_width(PWRUP_WAIT_CYCLES, RESET_PULSE_CYCLES,
                                LOCK_TIMEOUT_CYCLES, LOCK_FILTER_CYCLES);

  localparam logic [CW-1:0] PWRUP_LAST   = CW'(PWRUP_WAIT_CYCLES - 1);
  localparam logic [CW-1:0] PULSE_LAST   = CW'(RESET_PULSE_CYCLES - 1);
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] FILTER_LAST  = CW'(LOCK_FILTER_CYCLES - 1);
  // The WAIT_LOCK cycle that first sees lock already counts as one filtered high.
  localparam logic [CW-1:0] FILTER_ENTRY_LAST =
    CW'((LOCK_FILTER_CYCLES > 1) ? LOCK_FILTER_CYCLES - 2 : 0);
  localparam logic [2:0] LOCK_NEXT = (LOCK_FILTER_CYCLES > 1) ? S_LOCK_FILTER : S_READY;
  localparam logic [3:0] MAX_RETRY = 4'(MAX_RETRIES);

  logic [1:0]    sync_q;
  logic          lock_s;
  logic          lost_s;
  logic [2:0]    state_q;
  logic [2:0]    state_d;
  logic [CW-1:0] cnt_q;
  logic          cnt_restart;
  logic          timeout;
  logic [3:0]    retry_q;
  logic          qpllreset_q;
  logic          ready_q;
  logic          fail_q;

  sync_2ff #(.WIDTH(2)) u_sync (
    .clk (SYSCLK_IN),
    .rst (RESET_IN),
    .d   ({qpll.QPLLREFCLKLOST_IN, qpll.QPLLLOCK_IN}),
    .q   (sync_q)
  );

  assign lock_s = sync_q[0];
  assign lost_s = sync_q[1];

  always_comb begin
    state_d     = state_q;
    cnt_restart = 1'b0;
    timeout     = 1'b0;
    case (state_q)
      S_PWRUP_WAIT:
        if (cnt_q == PWRUP_LAST) state_d = lost_s ? S_WAIT_REFCLK : S_WAIT_LOCK;
      S_ASSERT_RST:
        if (lost_s) state_d = S_WAIT_REFCLK;
        else if (cnt_q == PULSE_LAST) state_d = S_WAIT_LOCK;
      S_WAIT_LOCK:
        if (lost_s) state_d = S_WAIT_REFCLK;
        else if (lock_s) state_d = LOCK_NEXT;
        else if (cnt_q == TIMEOUT_LAST) begin
          timeout = 1'b1;
          state_d = ((MAX_RETRIES != 0) && (retry_q == MAX_RETRY)) ? S_FAIL : S_ASSERT_RST;
        end
      S_LOCK_FILTER:
        if (lost_s) state_d = S_WAIT_REFCLK;
        else if (!lock_s) state_d = S_WAIT_LOCK;
        else if (cnt_q == FILTER_ENTRY_LAST) state_d = S_READY;
      S_READY:
        if (lost_s) state_d = S_WAIT_REFCLK;
        else if (!lock_s) state_d = S_ASSERT_RST;
      S_WAIT_REFCLK:
        if (lost_s) cnt_restart = 1'b1;
        else if (cnt_q == FILTER_LAST) state_d = S_ASSERT_RST;
      S_FAIL:
        state_d = S_FAIL;
      default:
        state_d = S_PWRUP_WAIT;
    endcase
  end

  // Outputs are decoded from the next state so they change with the state register.
  always_ff @(posedge SYSCLK_IN) begin
    if (RESET_IN) begin
      state_q     <= S_PWRUP_WAIT;
      cnt_q       <= '0;
      retry_q     <= '0;
      qpllreset_q <= 1'b1;
      ready_q     <= 1'b0;
      fail_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      if ((state_d != state_q) || cnt_restart) cnt_q <= '0;
      else if ((state_q != S_READY) && (state_q != S_FAIL)) cnt_q <= cnt_q + CW'(1);
      if (timeout && (retry_q != 4'hF)) retry_q <= retry_q + 4'd1;
      qpllreset_q <= (state_d == S_PWRUP_WAIT) || (state_d == S_ASSERT_RST) ||
                     (state_d == S_WAIT_REFCLK) || (state_d == S_FAIL);
      ready_q     <= (state_d == S_READY);
      fail_q      <= (state_d == S_FAIL);
    end
  end

  assign qpll.QPLLRESET_OUT   = qpllreset_q;
  assign qpll.QPLL_READY_OUT  = ready_q;
  assign qpll.FAIL_OUT        = fail_q;
  assign qpll.RETRY_COUNT_OUT = retry_q;
  assign qpll.STATE_OUT       = state_q;

endmodule

// File: tb/tb_qpll_reset_ctrl.sv
// Self-checking bench for qpll_reset_ctrl: scenario tasks compare the DUT
// against event timings derived from the sequencing rules.
module tb_qpll_reset_ctrl;

  localparam int PWRUP   = 20;
  localparam int PULSE   = 4;
  localparam int TIMEOUT = 100;
  localparam int FILTER  = 4;
  localparam int MAXR    = 2;
  localparam int SYNC    = 2;

  localparam logic [2:0] E_PWRUP  = 3'd0;
  localparam logic [2:0] E_ASSERT = 3'd1;
  localparam logic [2:0] E_WLOCK  = 3'd2;
  localparam logic [2:0] E_FILTER = 3'd3;
  localparam logic [2:0] E_READY  = 3'd4;
  localparam logic [2:0] E_REFCLK = 3'd5;
  localparam logic [2:0] E_FAIL   = 3'd6;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  qpll_reset_ctrl_if qif();

  qpll_reset_ctrl #(
    .PWRUP_WAIT_CYCLES   (PWRUP),
    .RESET_PULSE_CYCLES  (PULSE),
    .LOCK_TIMEOUT_CYCLES (TIMEOUT),
    .LOCK_FILTER_CYCLES  (FILTER),
    .MAX_RETRIES         (MAXR)
  ) dut (
    .SYSCLK_IN (clk),
    .RESET_IN  (rst),
    .qpll      (qif)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    qif.QPLLLOCK_IN = 1'b0;
    qif.QPLLREFCLKLOST_IN = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
  endtask

  task automatic wait_pwrup(output int n);
    n = 0;
    do begin tick(); n++; end while (qif.QPLLRESET_OUT !== 1'b0 && n < 1000);
  endtask

  // Expected QPLLRESET level t cycles after release with lock never asserting.
  function automatic logic exp_rst_nolock(input int t);
    int r;
    if (t < PWRUP) return 1'b1;
    r = (t - PWRUP) % (TIMEOUT + PULSE);
    return (r >= TIMEOUT);
  endfunction

  task automatic test_reset();
    logic [9:0] got;
    rst = 1'b1;
    qif.QPLLLOCK_IN = 1'b1;
    qif.QPLLREFCLKLOST_IN = 1'b0;
    repeat (3) tick();
    got = {qif.QPLLRESET_OUT, qif.QPLL_READY_OUT, qif.FAIL_OUT, qif.RETRY_COUNT_OUT, qif.STATE_OUT};
    checks++;
    if (got !== {1'b1, 1'b0, 1'b0, 4'd0, E_PWRUP}) begin
      errors++;
      $display("FAIL reset_values: got %b want %b", got, {1'b1, 1'b0, 1'b0, 4'd0, E_PWRUP});
    end
    qif.QPLLLOCK_IN = 1'b0;
  endtask

  task automatic test_normal_lock();
    int n, d;
    for (int it = 0; it < 3; it++) begin
      d = (it == 0) ? 30 : int'($urandom_range(5, 80));
      do_reset();
      wait_pwrup(n);
      checks++;
      if (n !== PWRUP) begin
        errors++;
        $display("FAIL pwrup_width: got %0d want %0d", n, PWRUP);
      end
      checks++;
      if (qif.STATE_OUT !== E_WLOCK) begin
        errors++;
        $display("FAIL pwrup_next_state: got %0d want %0d", qif.STATE_OUT, E_WLOCK);
      end
      repeat (d) tick();
      qif.QPLLLOCK_IN = 1'b1;
      n = 0;
      do begin tick(); n++; end while (qif.QPLL_READY_OUT !== 1'b1 && n < 50);
      checks++;
      if (n !== SYNC + FILTER) begin
        errors++;
        $display("FAIL lock_to_ready d=%0d: got %0d cycles want %0d", d, n, SYNC + FILTER);
      end
      checks++;
      if ({qif.RETRY_COUNT_OUT, qif.STATE_OUT, qif.QPLLRESET_OUT} !== {4'd0, E_READY, 1'b0}) begin
        errors++;
        $display("FAIL ready_status: retry=%0d state=%0d rst=%b want 0 4 0",
                 qif.RETRY_COUNT_OUT, qif.STATE_OUT, qif.QPLLRESET_OUT);
      end
    end
  endtask

  task automatic test_lock_loss();
    int len, fall_t, low_t, rdy_t, exp_rdy;
    logic rst_at_fall;
    for (int it = 0; it < 4; it++) begin
      len = (it == 0) ? 1 : int'($urandom_range(1, 6));
      checks++;
      if (qif.STATE_OUT !== E_READY) begin
        errors++;
        $display("FAIL loss_precondition: state %0d want %0d", qif.STATE_OUT, E_READY);
      end
      qif.QPLLLOCK_IN = 1'b0;
      fall_t = 0; low_t = 0; rdy_t = 0; rst_at_fall = 1'b0;
      for (int t = 1; t <= 60 && rdy_t == 0; t++) begin
        tick();
        if (t == len) qif.QPLLLOCK_IN = 1'b1;
        if (fall_t == 0 && qif.QPLL_READY_OUT === 1'b0) begin
          fall_t = t;
          rst_at_fall = qif.QPLLRESET_OUT;
        end else if (fall_t != 0 && low_t == 0 && qif.QPLLRESET_OUT === 1'b0) low_t = t;
        if (fall_t != 0 && qif.QPLL_READY_OUT === 1'b1) rdy_t = t;
      end
      exp_rdy = ((SYNC + 1 + PULSE + 1) > (len + SYNC + 1) ? (SYNC + 1 + PULSE + 1)
                                                          : (len + SYNC + 1)) + FILTER - 1;
      checks++;
      if (fall_t !== SYNC + 1 || rst_at_fall !== 1'b1) begin
        errors++;
        $display("FAIL loss_ready_fall: at %0d rst=%b want %0d rst=1", fall_t, rst_at_fall, SYNC + 1);
      end
      checks++;
      if (low_t !== SYNC + 1 + PULSE) begin
        errors++;
        $display("FAIL loss_pulse_end: at %0d want %0d", low_t, SYNC + 1 + PULSE);
      end
      checks++;
      if (rdy_t !== exp_rdy || qif.RETRY_COUNT_OUT !== 4'd0) begin
        errors++;
        $display("FAIL loss_relock len=%0d: ready at %0d retry %0d want %0d retry 0",
                 len, rdy_t, qif.RETRY_COUNT_OUT, exp_rdy);
      end
    end
  endtask

  task automatic test_refclk_lost();
    int n, d, w, hi_t, asrt_t, low_t, bad_state;
    for (int it = 0; it < 2; it++) begin
      d = (it == 0) ? 50 : int'($urandom_range(10, 60));
      w = $urandom_range(5, 40);
      do_reset();
      wait_pwrup(n);
      repeat (w) tick();
      qif.QPLLREFCLKLOST_IN = 1'b1;
      hi_t = 0; asrt_t = 0; low_t = 0; bad_state = 0;
      for (int t = 1; t <= d + 40 && low_t == 0; t++) begin
        tick();
        if (t == d) qif.QPLLREFCLKLOST_IN = 1'b0;
        if (hi_t == 0 && qif.QPLLRESET_OUT === 1'b1) hi_t = t;
        if (t >= SYNC + 1 && t < d + SYNC + FILTER && qif.STATE_OUT !== E_REFCLK) bad_state++;
        if (asrt_t == 0 && qif.STATE_OUT === E_ASSERT) asrt_t = t;
        if (asrt_t != 0 && qif.QPLLRESET_OUT === 1'b0) low_t = t;
      end
      checks++;
      if (hi_t !== SYNC + 1 || bad_state !== 0) begin
        errors++;
        $display("FAIL lost_hold: rst high at %0d want %0d, %0d cycles not in WAIT_REFCLK",
                 hi_t, SYNC + 1, bad_state);
      end
      checks++;
      if (asrt_t !== d + SYNC + FILTER) begin
        errors++;
        $display("FAIL lost_release d=%0d: pulse state at %0d want %0d", d, asrt_t, d + SYNC + FILTER);
      end
      checks++;
      if (low_t !== d + SYNC + FILTER + PULSE) begin
        errors++;
        $display("FAIL lost_pulse_end: at %0d want %0d", low_t, d + SYNC + FILTER + PULSE);
      end
      qif.QPLLLOCK_IN = 1'b1;
      n = 0;
      do begin tick(); n++; end while (qif.QPLL_READY_OUT !== 1'b1 && n < 50);
      checks++;
      if (n !== SYNC + FILTER || qif.RETRY_COUNT_OUT !== 4'd0) begin
        errors++;
        $display("FAIL lost_relock: %0d cycles retry %0d want %0d retry 0",
                 n, qif.RETRY_COUNT_OUT, SYNC + FILTER);
      end
    end
  endtask

  task automatic test_glitch();
    int n, d;
    bit saw_ready, saw_rst, saw_filter, saw_retry;
    do_reset();
    wait_pwrup(n);
    d = $urandom_range(0, 50);
    repeat (d) tick();
    saw_ready = 0; saw_rst = 0; saw_filter = 0; saw_retry = 0;
    for (int t = 1; t <= 400; t++) begin
      qif.QPLLLOCK_IN = (t % 4 != 0);
      tick();
      if (qif.QPLL_READY_OUT === 1'b1 || qif.STATE_OUT === E_READY) saw_ready = 1;
      if (qif.QPLLRESET_OUT !== 1'b0) saw_rst = 1;
      if (qif.STATE_OUT === E_FILTER) saw_filter = 1;
      if (qif.RETRY_COUNT_OUT !== 4'd0) saw_retry = 1;
    end
    qif.QPLLLOCK_IN = 1'b0;
    checks++;
    if (saw_ready) begin
      errors++;
      $display("FAIL glitch_never_ready: ready seen 1 want never");
    end
    checks++;
    if (saw_rst || saw_retry) begin
      errors++;
      $display("FAIL glitch_timeout_restart: rst_seen=%0b retry_seen=%0b want 0 0", saw_rst, saw_retry);
    end
    checks++;
    if (!saw_filter) begin
      errors++;
      $display("FAIL glitch_filter_entry: LOCK_FILTER seen 0 want 1");
    end
  endtask

  task automatic test_timeout_fail();
    int mism, first_bad, fail_t, exp_fail;
    logic [3:0] retry_first;
    do_reset();
    mism = 0; first_bad = 0; fail_t = 0; retry_first = 4'hx;
    for (int t = 1; t <= 1000 && fail_t == 0; t++) begin
      tick();
      if (qif.QPLLRESET_OUT !== exp_rst_nolock(t)) begin
        mism++;
        if (first_bad == 0) first_bad = t;
      end
      if (t == PWRUP + TIMEOUT) retry_first = qif.RETRY_COUNT_OUT;
      if (qif.FAIL_OUT === 1'b1) fail_t = t;
    end
    exp_fail = PWRUP + MAXR * (TIMEOUT + PULSE) + TIMEOUT;
    checks++;
    if (mism !== 0) begin
      errors++;
      $display("FAIL timeout_waveform: %0d wrong cycles, first at %0d, want 0", mism, first_bad);
    end
    checks++;
    if (retry_first !== 4'd1) begin
      errors++;
      $display("FAIL timeout_first_retry: got %0d want 1", retry_first);
    end
    checks++;
    if (fail_t !== exp_fail) begin
      errors++;
      $display("FAIL timeout_fail_time: got %0d want %0d", fail_t, exp_fail);
    end
    checks++;
    if ({qif.QPLLRESET_OUT, qif.QPLL_READY_OUT, qif.RETRY_COUNT_OUT, qif.STATE_OUT} !==
        {1'b1, 1'b0, 4'(MAXR + 1), E_FAIL}) begin
      errors++;
      $display("FAIL fail_outputs: rst=%b rdy=%b retry=%0d state=%0d want 1 0 %0d %0d",
               qif.QPLLRESET_OUT, qif.QPLL_READY_OUT, qif.RETRY_COUNT_OUT, qif.STATE_OUT,
               MAXR + 1, E_FAIL);
    end
    qif.QPLLLOCK_IN = 1'b1;
    repeat (30) tick();
    checks++;
    if (qif.FAIL_OUT !== 1'b1 || qif.STATE_OUT !== E_FAIL) begin
      errors++;
      $display("FAIL fail_sticky: fail=%b state=%0d want 1 %0d", qif.FAIL_OUT, qif.STATE_OUT, E_FAIL);
    end
  endtask

  task automatic test_reset_override();
    int n;
    logic [9:0] got;
    rst = 1'b1;
    tick();
    got = {qif.QPLLRESET_OUT, qif.QPLL_READY_OUT, qif.FAIL_OUT, qif.RETRY_COUNT_OUT, qif.STATE_OUT};
    checks++;
    if (got !== {1'b1, 1'b0, 1'b0, 4'd0, E_PWRUP}) begin
      errors++;
      $display("FAIL reset_from_fail: got %b want %b", got, {1'b1, 1'b0, 1'b0, 4'd0, E_PWRUP});
    end
    rst = 1'b0;
    qif.QPLLLOCK_IN = 1'b0;
    wait_pwrup(n);
    qif.QPLLLOCK_IN = 1'b1;
    repeat (SYNC + 1) tick();
    checks++;
    if (qif.STATE_OUT !== E_FILTER) begin
      errors++;
      $display("FAIL filter_entry: state %0d want %0d", qif.STATE_OUT, E_FILTER);
    end
    rst = 1'b1;
    tick();
    got = {qif.QPLLRESET_OUT, qif.QPLL_READY_OUT, qif.FAIL_OUT, qif.RETRY_COUNT_OUT, qif.STATE_OUT};
    checks++;
    if (got !== {1'b1, 1'b0, 1'b0, 4'd0, E_PWRUP}) begin
      errors++;
      $display("FAIL reset_from_filter: got %b want %b", got, {1'b1, 1'b0, 1'b0, 4'd0, E_PWRUP});
    end
    rst = 1'b0;
  endtask

  initial begin
    qif.QPLLLOCK_IN = 1'b0;
    qif.QPLLREFCLKLOST_IN = 1'b0;
    test_reset();
    test_normal_lock();
    test_lock_loss();
    test_refclk_lost();
    test_glitch();
    test_timeout_fail();
    test_reset_override();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
